// File: rtl/apb_btn_req_gen.sv
// Button/switch front end for the APB master: synchronizes and debounces the push-button,
// issues one trigger per press with a switch snapshot, and interlocks until the transfer ends.
module apb_btn_req_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        btn_raw,
    input  logic [15:0] sw_raw,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        trigger,
    output logic [15:0] req_sw,
    output logic        busy,
    output logic        err_flag,
    output logic [7:0]  press_count
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        ISSUE,
        WAIT_XFER,
        DEB_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic              err_next;
    logic              xfer_done;
    logic              timeout_hit;

    logic              btn_meta;
    logic              btn_s;
    logic [15:0]       sw_meta;
    logic [15:0]       sw_s;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            sw_meta  <= '0;
            sw_s     <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
            sw_meta  <= sw_raw;
            sw_s     <= sw_meta;
        end
    end

    assign xfer_done = PSEL & PENABLE & PREADY;
    assign cnt_inc   = cnt + CNT_W'(1);
    // The timeout fires as the count steps onto its last value, so err_flag lands
    // exactly TIMEOUT_CYCLES after the trigger cycle.
    assign timeout_hit = (cnt_inc >= TO_LAST);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = err_flag;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (btn_s) begin
                    state_next = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next = ISSUE;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ISSUE: begin
                state_next = WAIT_XFER;
                cnt_next   = '0;
            end
            WAIT_XFER: begin
                if (xfer_done) begin
                    state_next = DEB_RELEASE;
                    cnt_next   = '0;
                    err_next   = PSLVERR;
                end else if (timeout_hit) begin
                    state_next = DEB_RELEASE;
                    cnt_next   = '0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            DEB_RELEASE: begin
                if (btn_s) begin
                    cnt_next = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            trigger     <= 1'b0;
            busy        <= 1'b0;
            err_flag    <= 1'b0;
            req_sw      <= '0;
            press_count <= '0;
        end else begin
            trigger  <= (state_next == ISSUE);
            busy     <= (state_next == ISSUE) || (state_next == WAIT_XFER) ||
                        (state_next == DEB_RELEASE);
            err_flag <= err_next;
            if (state_next == ISSUE) begin
                req_sw      <= sw_s;
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule
